// File: rtl/decoder_iter_ctrl.sv
// ============================================================================
// Module   : decoder_iter_ctrl
// Brief    : Iteration sequencer for the unrolled min-sum decoder layer.
//            Captures one frame of channel LLRs, then runs N_ITER layer
//            cycles while feeding edge messages back to the layer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_iter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int N_V      = 44,
    parameter int E        = 147,
    parameter int N_ITER   = 5,
    parameter int INT_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*N_V-1:0]  in_llrs,
    output logic [INT_SIZE-1:0]   layer_bias_idx,
    output logic [WIDTH*N_V-1:0]  layer_all_llrs,
    output logic [WIDTH*E-1:0]    layer_prev_proc_elem,
    input  logic [WIDTH*E-1:0]    layer_proc_elem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH*E-1:0]    out_proc_elem,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [INT_SIZE-1:0] LAST_ITER = INT_SIZE'(N_ITER - 1);

    state_t                 state_q, state_d;
    logic [WIDTH*N_V-1:0]   llr_q, llr_d;
    logic [WIDTH*E-1:0]     edge_q, edge_d;
    logic [INT_SIZE-1:0]    iter_q, iter_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            llr_q   <= '0;
            edge_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            llr_q   <= llr_d;
            edge_q  <= edge_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        llr_d   = llr_q;
        edge_d  = edge_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    llr_d   = in_llrs;
                    edge_d  = '0;
                    iter_d  = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // The layer is never stalled: every ITER cycle captures its result.
                edge_d = layer_proc_elem;
                if (iter_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    iter_d = iter_q + INT_SIZE'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    iter_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready             = (state_q == S_IDLE);
    assign out_valid            = (state_q == S_DONE);
    assign busy                 = (state_q != S_IDLE);
    assign layer_bias_idx       = iter_q;
    assign layer_all_llrs       = llr_q;
    assign layer_prev_proc_elem = edge_q;
    assign out_proc_elem        = edge_q;

endmodule

`default_nettype wire
